// File: rtl/vga_video_source.sv
// VGA timing generator: sync pulses, visible-window flags, linear pixel address,
// and a look-ahead read port that leads the displayed pixel by PREFETCH cycles.
module vga_video_source #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 20,
  parameter int PREFETCH = 1,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W     = $clog2(H_TOTAL),
  localparam int Y_W     = $clog2(V_TOTAL)
) (
  input  logic              VGA_clock,
  input  logic              reset_n,
  input  logic              enable,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              h_sync,
  output logic              v_sync,
  output logic              active_area,
  output logic [X_W-1:0]    x_pos,
  output logic [Y_W-1:0]    y_pos,
  output logic [ADDR_W-1:0] vAddress,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              frame_start,
  output logic              line_start
);

  localparam logic [X_W-1:0]    X_LAST    = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0]    X_VIS     = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0]    HS_BEG    = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0]    HS_END    = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0]    Y_VIS     = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0]    VS_BEG    = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0]    VS_END    = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  // The look-ahead starts PREFETCH positions into row 0, having already passed
  // however many visible pixels lie before it.
  localparam logic [X_W-1:0]    LA_X_RST  = X_W'(PREFETCH);
  localparam logic [ADDR_W-1:0] LA_A_RST  = ADDR_W'(PREFETCH < H_ACTIVE ? PREFETCH : H_ACTIVE);

  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] addr;   // address of this pixel, or of the next visible one
  } pos_t;

  typedef struct packed {
    logic              hs;
    logic              vs;
    logic              h_vis;
    logic              v_vis;
    logic              act;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] vaddr;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              fs;
    logic              ls;
  } out_t;

  pos_t pos_q, pos_d;
  pos_t la_q,  la_d;
  out_t out_q, out_d;

  function automatic logic visible(input pos_t p);
    return (p.x < X_VIS) && (p.y < Y_VIS);
  endfunction

  function automatic pos_t advance(input pos_t p);
    pos_t n;
    n = p;
    if (p.x == X_LAST) begin
      n.x = '0;
      n.y = (p.y == Y_LAST) ? '0 : p.y + Y_W'(1);
    end else begin
      n.x = p.x + X_W'(1);
    end
    if (visible(p)) n.addr = (p.addr == ADDR_LAST) ? '0 : p.addr + ADDR_W'(1);
    return n;
  endfunction

  always_comb begin
    // NOTE: every *_d gets a default before any branch, so no path leaves it unassigned (no latch).
    pos_d = pos_q;
    la_d  = la_q;
    out_d = out_q;
    if (enable) begin
      pos_d         = advance(pos_q);
      la_d          = advance(la_q);
      out_d.x       = pos_q.x;
      out_d.y       = pos_q.y;
      out_d.h_vis   = pos_q.x < X_VIS;
      out_d.v_vis   = pos_q.y < Y_VIS;
      out_d.act     = visible(pos_q);
      out_d.hs      = !((pos_q.x >= HS_BEG) && (pos_q.x < HS_END));
      out_d.vs      = !((pos_q.y >= VS_BEG) && (pos_q.y < VS_END));
      out_d.vaddr   = pos_q.addr;
      out_d.fs      = (pos_q.x == '0) && (pos_q.y == '0);
      out_d.ls      = (pos_q.x == '0) && (pos_q.y < Y_VIS);
      out_d.rd_req  = visible(la_q);
      out_d.rd_addr = la_q.addr;
    end
  end

  // NOTE: clocked state uses non-blocking assignments only, so all flops sample together.
  always_ff @(posedge VGA_clock or negedge reset_n) begin
    if (!reset_n) begin
      pos_q      <= '0;
      la_q.x     <= LA_X_RST;
      la_q.y     <= '0;
      la_q.addr  <= LA_A_RST;
      out_q      <= '0;
      out_q.hs   <= 1'b1;
      out_q.vs   <= 1'b1;
    end else begin
      pos_q <= pos_d;
      la_q  <= la_d;
      out_q <= out_d;
    end
  end

  assign vga_hs      = out_q.hs;
  assign vga_vs      = out_q.vs;
  assign h_sync      = out_q.h_vis;
  assign v_sync      = out_q.v_vis;
  assign active_area = out_q.act;
  assign x_pos       = out_q.x;
  assign y_pos       = out_q.y;
  assign vAddress    = out_q.vaddr;
  assign rd_req      = out_q.rd_req;
  assign rd_addr     = out_q.rd_addr;
  assign frame_start = out_q.fs;
  assign line_start  = out_q.ls;

endmodule

// File: tb/tb_vga_video_source.sv
// Directed bench: full-size timing (PREFETCH=4) at chosen points, plus a tiny
// 7x6 configuration (PREFETCH=1) checked every cycle against a closed-form model.
module tb_vga_video_source;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Full-size instance
  logic        b_hs, b_vs, b_hv, b_vv, b_act, b_rdreq, b_fs, b_ls;
  logic [9:0]  b_x, b_y;
  logic [19:0] b_vaddr, b_rdaddr;

  // Tiny instance: H 4+1+1+1 = 7, V 3+1+1+1 = 6, 42-cycle frame
  logic        s_hs, s_vs, s_hv, s_vv, s_act, s_rdreq, s_fs, s_ls;
  logic [2:0]  s_x, s_y;
  logic [3:0]  s_vaddr, s_rdaddr;

  vga_video_source #(.PREFETCH(4)) u_big (
    .VGA_clock(clk), .reset_n(rst_n), .enable(enable),
    .vga_hs(b_hs), .vga_vs(b_vs), .h_sync(b_hv), .v_sync(b_vv),
    .active_area(b_act), .x_pos(b_x), .y_pos(b_y), .vAddress(b_vaddr),
    .rd_req(b_rdreq), .rd_addr(b_rdaddr), .frame_start(b_fs), .line_start(b_ls)
  );

  vga_video_source #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .ADDR_W(4), .PREFETCH(1)
  ) u_small (
    .VGA_clock(clk), .reset_n(rst_n), .enable(enable),
    .vga_hs(s_hs), .vga_vs(s_vs), .h_sync(s_hv), .v_sync(s_vv),
    .active_area(s_act), .x_pos(s_x), .y_pos(s_y), .vAddress(s_vaddr),
    .rd_req(s_rdreq), .rd_addr(s_rdaddr), .frame_start(s_fs), .line_start(s_ls)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Tiny-config model: position p in 0..41 of the frame.
  function automatic bit s_vis(input int p);
    return ((p % 7) < 4) && ((p / 7) < 3);
  endfunction

  function automatic int s_addr(input int p);
    int x, y, n;
    x = p % 7;
    y = p / 7;
    n = (y < 3) ? (y * 4 + ((x < 4) ? x : 4)) : 12;
    return n % 12;
  endfunction

  task automatic check_small(input int p);
    int x, y, q;
    x = p % 7;
    y = p / 7;
    q = (p + 1) % 42;
    check("s_x_pos",   s_x,     x);
    check("s_y_pos",   s_y,     y);
    check("s_active",  s_act,   s_vis(p));
    check("s_h_sync",  s_hv,    x < 4);
    check("s_v_sync",  s_vv,    y < 3);
    check("s_vga_hs",  s_hs,    (x == 5) ? 0 : 1);
    check("s_vga_vs",  s_vs,    (y == 4) ? 0 : 1);
    check("s_frame",   s_fs,    p == 0);
    check("s_line",    s_ls,    (x == 0) && (y < 3));
    check("s_vaddr",   s_vaddr, s_addr(p));
    check("s_rd_req",  s_rdreq, s_vis(q));
    if (s_vis(q)) check("s_rd_addr", s_rdaddr, s_addr(q));
  endtask

  task automatic check_reset();
    check("rst_b_hs",    b_hs,     1);
    check("rst_b_vs",    b_vs,     1);
    check("rst_b_hv",    b_hv,     0);
    check("rst_b_vv",    b_vv,     0);
    check("rst_b_act",   b_act,    0);
    check("rst_b_x",     b_x,      0);
    check("rst_b_y",     b_y,      0);
    check("rst_b_vaddr", b_vaddr,  0);
    check("rst_b_rdreq", b_rdreq,  0);
    check("rst_b_rdadr", b_rdaddr, 0);
    check("rst_b_fs",    b_fs,     0);
    check("rst_b_ls",    b_ls,     0);
    check("rst_s_hs",    s_hs,     1);
    check("rst_s_vs",    s_vs,     1);
    check("rst_s_act",   s_act,    0);
    check("rst_s_x",     s_x,      0);
    check("rst_s_vaddr", s_vaddr,  0);
    check("rst_s_rdreq", s_rdreq,  0);
    check("rst_s_fs",    s_fs,     0);
    check("rst_s_ls",    s_ls,     0);
  endtask

  initial begin
    rst_n  = 1'b1;
    enable = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Edge k shows full-size pixel k of row 0.., tiny pixel k mod 42.
    for (int k = 0; k <= 8300; k++) begin
      @(negedge clk);
      if (k < 126) check_small(k % 42);
      case (k)
        0: begin
          check("b0_fs",     b_fs,     1);
          check("b0_ls",     b_ls,     1);
          check("b0_act",    b_act,    1);
          check("b0_vaddr",  b_vaddr,  0);
          check("b0_rdreq",  b_rdreq,  1);
          check("b0_rdaddr", b_rdaddr, 4);
        end
        639: begin
          check("b639_x",     b_x,     639);
          check("b639_act",   b_act,   1);
          check("b639_vaddr", b_vaddr, 639);
          check("b639_rdreq", b_rdreq, 0);
        end
        640: begin
          check("b640_act",   b_act,   0);
          check("b640_hv",    b_hv,    0);
          check("b640_vaddr", b_vaddr, 640);
        end
        655: check("b655_hs", b_hs, 1);
        656: check("b656_hs", b_hs, 0);
        751: check("b751_hs", b_hs, 0);
        752: check("b752_hs", b_hs, 1);
        795: check("b795_rdreq", b_rdreq, 0);
        796: begin
          check("b796_rdreq",  b_rdreq,  1);
          check("b796_rdaddr", b_rdaddr, 640);
        end
        800: begin
          check("b800_x",      b_x,      0);
          check("b800_y",      b_y,      1);
          check("b800_vaddr",  b_vaddr,  640);
          check("b800_ls",     b_ls,     1);
          check("b800_fs",     b_fs,     0);
          check("b800_act",    b_act,    1);
          check("b800_rdaddr", b_rdaddr, 644);
        end
        8300: begin
          check("b8300_x",     b_x,     300);
          check("b8300_y",     b_y,     10);
          check("b8300_vaddr", b_vaddr, 6700);
        end
        default: ;
      endcase
    end

    // Stall at (300,10): nothing may move.
    enable = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      check("hold_b_x",     b_x,     300);
      check("hold_b_vaddr", b_vaddr, 6700);
      check("hold_b_act",   b_act,   1);
      check("hold_b_ls",    b_ls,    0);
      check_small(8300 % 42);
    end
    enable = 1'b1;
    @(negedge clk);
    check("resume_b_x",     b_x,     301);
    check("resume_b_y",     b_y,     10);
    check("resume_b_vaddr", b_vaddr, 6701);
    check_small(8301 % 42);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1 check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rs_b_fs",     b_fs,     1);
    check("rs_b_x",      b_x,      0);
    check("rs_b_y",      b_y,      0);
    check("rs_b_vaddr",  b_vaddr,  0);
    check("rs_b_act",    b_act,    1);
    check("rs_b_rdaddr", b_rdaddr, 4);
    check_small(0);

    // Pulses stay high while stalled on pixel (0,0).
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_b_fs", b_fs, 1);
      check("hold_b_ls", b_ls, 1);
      check_small(0);
    end
    enable = 1'b1;
    for (int p = 1; p <= 84; p++) begin
      @(negedge clk);
      check_small(p % 42);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
